mxu_host_if: RTL

Register front-end that sits directly upstream of the matrix multiply unit. Accepts byte writes from a simple host write port and assembles them into the A/B operand buses and the cycles control bit. Issues the start pulse, tracks the run with a watchdog, and captures the SIZE*SIZE 32-bit accumulators when the unit signals done. Exposes status and results through a one-cycle-latency read port.

---
 rtl/mxu_host_if.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mxu_host_if.sv
// Host register front-end for the matrix multiply unit: assembles operands from byte writes,
// issues the start pulse, watches the run with a watchdog and captures the accumulators.
module mxu_host_if #(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RES_BASE = 64,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_valid,
  output logic [31:0]                rd_data,
  output logic [SIZE*SIZE*8-1:0]     data_a_out,
  output logic [SIZE*SIZE*8-1:0]     data_b_out,
  output logic                       cycles_out,
  output logic                       start_out,
  input  logic                       mxu_done_in,
  input  logic [SIZE*SIZE-1:0][31:0] d_in,
  output logic                       irq
);

  localparam int unsigned N     = SIZE * SIZE;
  localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ABase = 2;
  localparam int unsigned BBase = 2 + N;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [N-1:0][7:0]  a_q, b_q;
  logic [N-1:0][31:0] res_q;
  logic               cycles_q, start_q, done_q, timeout_q, rd_valid_q;
  logic [15:0]        run_cnt_q;
  logic [31:0]        rd_data_q, rd_word;
  logic [31:0]        wr_addr_w, rd_addr_w;
  logic               busy, wr_fire, ctrl_wr, start_req, timeout_hit;

  assign wr_addr_w   = 32'(wr_addr);
  assign rd_addr_w   = 32'(rd_addr);
  assign wr_fire     = wr_valid & wr_ready;
  assign ctrl_wr     = wr_fire && (wr_addr_w == 32'd0);
  assign start_req   = ctrl_wr && wr_data[0];
  assign timeout_hit = (state_q == StRun) && (32'(run_cnt_q) == TIMEOUT - 1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state; done takes priority over the watchdog
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_req) state_d = StRun;
      StRun:   if (mxu_done_in || timeout_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    wr_ready = (state_q == StIdle);
    busy     = (state_q == StRun);
  end

  assign data_a_out = a_q;
  assign data_b_out = b_q;
  assign cycles_out = cycles_q;
  assign start_out  = start_q;
  assign irq        = done_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

  // Operand and cycles registers change only on host writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      cycles_q <= 1'b0;
    end else if (wr_fire) begin
      if (wr_addr_w == 32'd1) cycles_q <= wr_data[0];
      for (int unsigned k = 0; k < N; k++) begin
        if (wr_addr_w == ABase + k) a_q[k[IdxW-1:0]] <= wr_data;
        if (wr_addr_w == BBase + k) b_q[k[IdxW-1:0]] <= wr_data;
      end
    end
  end

  // Run tracking, flags and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      run_cnt_q <= '0;
      res_q     <= '0;
    end else begin
      start_q <= start_req;
      if (start_req) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        run_cnt_q <= '0;
      end else if (state_q == StRun) begin
        if (run_cnt_q != 16'hFFFF) run_cnt_q <= run_cnt_q + 16'd1;
        if (mxu_done_in) begin
          done_q <= 1'b1;
          res_q  <= d_in;
        end else if (timeout_hit) begin
          timeout_q <= 1'b1;
        end
      end else if (ctrl_wr) begin
        if (wr_data[1]) done_q    <= 1'b0;
        if (wr_data[2]) timeout_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr_w == 32'd0) begin
      rd_word = {run_cnt_q, 13'b0, timeout_q, done_q, busy};
    end else if (rd_addr_w == 32'd1) begin
      rd_word = {31'b0, cycles_q};
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (rd_addr_w == RES_BASE + k) rd_word = res_q[k[IdxW-1:0]];
      end
    end
  end

  // One-cycle read latency; data holds when no request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= rd_word;
    end
  end

endmodule
